// File: rtl/mem_ctrl_pkg.sv
// Shared types, constants and byte-lane helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 17;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO32        = 32'h0000_0000;

  // Access length codes as presented on mem_len_in (2'b11 behaves as a word)
  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IF_RD  = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_t;

  // Number of RAM byte cycles for a length code
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

  // Mask that keeps only the low n bytes of a word (zero extension of loads)
  function automatic logic [31:0] lane_mask(input logic [2:0] n);
    logic [31:0] m;
    case (n)
      3'd1:    m = 32'h0000_00FF;
      3'd2:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Replace one little-endian byte lane of a word
  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r[31:24] = b;
    endcase
    return r;
  endfunction

  // Extract one little-endian byte lane of a word
  function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates a byte-wide single-port RAM between instruction fetch and the MEM stage.
// MEM wins ties because it holds the older instruction. Multi-byte accesses are
// serialised into one RAM cycle per byte and reads are reassembled little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_in,
  input  logic [31:0]       if_addr_in,
  output logic              if_done_out,
  output logic [31:0]       if_data_out,
  output logic              if_stall_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [1:0]        mem_len_in,
  input  logic [31:0]       mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic              mem_done_out,
  output logic [31:0]       mem_rdata_out,
  output logic              mem_stall_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_wr_out,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  state_t            state;
  state_t            state_next;
  logic [2:0]        cnt;
  logic [2:0]        cnt_next;
  logic [ADDR_W-1:0] base;
  logic [2:0]        nbytes;
  logic [31:0]       wdata;
  owner_t            owner;
  logic [31:0]       rbuf;

  logic              accept_mem;
  logic              accept_if;
  logic              finish_rd;
  logic              capture_en;
  logic [1:0]        rd_lane;
  logic [31:0]       asm_word;

  // Only the low ADDR_W address bits reach the RAM; the rest are ignored
  logic              unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_in[31:ADDR_W], mem_addr_in[31:ADDR_W]};

  // A byte requested at cnt-1 arrives on ram_din while cnt is current
  assign rd_lane    = 2'(cnt - 3'd1);
  assign capture_en = ((state == ST_IF_RD) || (state == ST_MEM_RD)) && (cnt != 3'd0);
  assign asm_word   = put_byte(rbuf, rd_lane, ram_din);

  assign if_done_out   = (state == ST_DONE) && (owner == OWN_IF);
  assign mem_done_out  = (state == ST_DONE) && (owner == OWN_MEM);
  assign if_stall_out  = if_req_in & ~if_done_out;
  assign mem_stall_out = mem_req_in & ~mem_done_out;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: arbitration, byte counting and IF flush
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    finish_rd  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_req_in) begin
          accept_mem = 1'b1;
          state_next = mem_we_in ? ST_MEM_WR : ST_MEM_RD;
          cnt_next   = 3'd0;
        end else if (if_req_in) begin
          accept_if  = 1'b1;
          state_next = ST_IF_RD;
          cnt_next   = 3'd0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_IF_RD: begin
        if (!if_req_in) begin
          state_next = ST_IDLE;
          cnt_next   = 3'd0;
        end else if (cnt == nbytes) begin
          state_next = ST_DONE;
          cnt_next   = 3'd0;
          finish_rd  = 1'b1;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      ST_MEM_RD: begin
        if (cnt == nbytes) begin
          state_next = ST_DONE;
          cnt_next   = 3'd0;
          finish_rd  = 1'b1;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      ST_MEM_WR: begin
        if (cnt == 3'(nbytes - 3'd1)) begin
          state_next = ST_DONE;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        cnt_next   = 3'd0;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Request latching, byte-lane assembly and result registers
  always_ff @(posedge clk_in) begin
    if (rst_in == RST_ENABLE) begin
      base          <= '0;
      nbytes        <= 3'd0;
      wdata         <= ZERO32;
      owner         <= OWN_IF;
      rbuf          <= ZERO32;
      if_data_out   <= ZERO32;
      mem_rdata_out <= ZERO32;
    end else begin
      if (accept_mem) begin
        base   <= mem_addr_in[ADDR_W-1:0];
        nbytes <= len_to_bytes(mem_len_in);
        wdata  <= mem_wdata_in;
        owner  <= OWN_MEM;
        rbuf   <= ZERO32;
      end else if (accept_if) begin
        base   <= if_addr_in[ADDR_W-1:0];
        nbytes <= 3'd4;
        owner  <= OWN_IF;
        rbuf   <= ZERO32;
      end else if (capture_en) begin
        rbuf <= asm_word;
      end
      if (finish_rd) begin
        if (owner == OWN_IF) begin
          if_data_out <= asm_word;
        end else begin
          mem_rdata_out <= asm_word & lane_mask(nbytes);
        end
      end
    end
  end

  // RAM port decode from the current state and byte counter
  always_comb begin
    ram_addr_out = '0;
    ram_wr_out   = WRITE_DISABLE;
    ram_dout     = 8'h00;
    case (state)
      ST_IF_RD, ST_MEM_RD: begin
        if (cnt < nbytes) begin
          ram_addr_out = base + ADDR_W'(cnt);
        end else begin
          ram_addr_out = '0;
        end
      end
      ST_MEM_WR: begin
        ram_addr_out = base + ADDR_W'(cnt);
        ram_wr_out   = WRITE_ENABLE;
        ram_dout     = get_byte(wdata, cnt[1:0]);
      end
      default: begin
        ram_addr_out = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: behavioural byte RAM, a table of single accesses driven
// through a scoreboard, and hand-written arbitration / flush / reset sequences.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          if_req_in = 1'b0;
  logic [31:0]   if_addr_in = 32'h0;
  logic          if_done_out;
  logic [31:0]   if_data_out;
  logic          if_stall_out;
  logic          mem_req_in = 1'b0;
  logic          mem_we_in = 1'b0;
  logic [1:0]    mem_len_in = 2'b00;
  logic [31:0]   mem_addr_in = 32'h0;
  logic [31:0]   mem_wdata_in = 32'h0;
  logic          mem_done_out;
  logic [31:0]   mem_rdata_out;
  logic          mem_stall_out;
  logic [AW-1:0] ram_addr_out;
  logic          ram_wr_out;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk_in(clk), .rst_in(rst_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
    .if_data_out(if_data_out), .if_stall_out(if_stall_out),
    .mem_req_in(mem_req_in), .mem_we_in(mem_we_in), .mem_len_in(mem_len_in),
    .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in), .mem_done_out(mem_done_out),
    .mem_rdata_out(mem_rdata_out), .mem_stall_out(mem_stall_out),
    .ram_addr_out(ram_addr_out), .ram_wr_out(ram_wr_out), .ram_dout(ram_dout),
    .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Byte RAM with one cycle read latency
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    ram_din <= ram[ram_addr_out];
    if (ram_wr_out) ram[ram_addr_out] <= ram_dout;
  end

  int total = 0;
  int bad = 0;

  typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
  wr_t         wr_q[$];
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  bit          mon_en = 1'b0;

  typedef struct {
    bit          is_if;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int len_n(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic vec_t mk_if(input logic [31:0] addr, input logic [31:0] exp);
    return '{is_if: 1'b1, we: 1'b0, len: 2'b10, addr: addr, wdata: 32'h0, exp: exp, lat: 6};
  endfunction

  function automatic vec_t mk_rd(input logic [1:0] len, input logic [31:0] addr,
                                 input logic [31:0] exp, input int lat);
    return '{is_if: 1'b0, we: 1'b0, len: len, addr: addr, wdata: 32'h0, exp: exp, lat: lat};
  endfunction

  function automatic vec_t mk_wr(input logic [1:0] len, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int lat);
    return '{is_if: 1'b0, we: 1'b1, len: len, addr: addr, wdata: wdata, exp: 32'h0, lat: lat};
  endfunction

  // Every RAM write must match the next expected write
  always @(negedge clk) begin : wr_mon
    wr_t e;
    if (mon_en && ram_wr_out) begin
      total++;
      if (wr_q.size() == 0) begin
        bad++;
        $display("FAIL wr_spurious: got write %h=%h expected no write", ram_addr_out, ram_dout);
      end else begin
        e = wr_q.pop_front();
        if (ram_addr_out !== e.addr || ram_dout !== e.data) begin
          bad++;
          $display("FAIL wr_byte: got %h=%h expected %h=%h", ram_addr_out, ram_dout, e.addr, e.data);
        end
      end
    end
  end

  // One access from a negedge in IDLE through done and one hold cycle
  task automatic run_op(input vec_t v, input string tag);
    int n, cyc;
    bit done_seen, stall_bad, addr_bad, other_done;
    logic d, od, st;
    logic [31:0] got, exp;
    n = v.is_if ? 4 : len_n(v.len);
    exp = 32'h0;
    if (v.we) begin
      for (int i = 0; i < n; i++) wr_q.push_back('{addr: AW'(v.addr + i), data: v.wdata[8*i +: 8]});
    end else if (v.is_if) begin
      if_q.push_back(v.exp);
    end else begin
      mem_q.push_back(v.exp);
    end
    if (v.is_if) begin
      if_req_in = 1'b1; if_addr_in = v.addr;
    end else begin
      mem_req_in = 1'b1; mem_we_in = v.we; mem_len_in = v.len;
      mem_addr_in = v.addr; mem_wdata_in = v.wdata;
    end
    cyc = 0; done_seen = 0; stall_bad = 0; addr_bad = 0; other_done = 0; got = 32'h0;
    while (!done_seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      d  = v.is_if ? if_done_out : mem_done_out;
      od = v.is_if ? mem_done_out : if_done_out;
      st = v.is_if ? if_stall_out : mem_stall_out;
      if (od) other_done = 1;
      if (!v.we && cyc <= n && ram_addr_out !== AW'(v.addr + cyc - 1)) addr_bad = 1;
      if (d) begin
        done_seen = 1;
        got = v.is_if ? if_data_out : mem_rdata_out;
        check({tag, "_stall_at_done"}, {31'h0, st}, 32'h0);
      end else if (st !== 1'b1) begin
        stall_bad = 1;
      end
    end
    check({tag, "_latency"}, 32'(cyc), 32'(v.lat));
    check({tag, "_protocol"}, {29'h0, stall_bad, addr_bad, other_done}, 32'h0);
    if (!v.we) begin
      if (v.is_if) exp = (if_q.size() > 0) ? if_q.pop_front() : 32'hX;
      else         exp = (mem_q.size() > 0) ? mem_q.pop_front() : 32'hX;
      check({tag, "_data"}, got, exp);
    end
    if (v.is_if) if_req_in = 1'b0; else mem_req_in = 1'b0;
    @(negedge clk);
    if (!v.we) check({tag, "_hold"}, v.is_if ? if_data_out : mem_rdata_out, exp);
    check({tag, "_wr_drain"}, 32'(wr_q.size()), 32'h0);
  endtask

  initial begin
    int mem_cyc, if_cyc, bad_flag;
    logic [31:0] mem_got, if_got;

    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    ram[17'h00100] = 8'h13; ram[17'h00101] = 8'h05;
    ram[17'h02000] = 8'h34; ram[17'h02001] = 8'hF2;
    ram[17'h00301] = 8'h22;
    ram[17'h00200] = 8'h93; ram[17'h00202] = 8'h10;
    ram[17'h1FFFE] = 8'h5A; ram[17'h00001] = 8'h7E;
    ram[17'h00502] = 8'hEE; ram[17'h00503] = 8'hFF;

    vecs[0]  = mk_if(32'h0000_0100, 32'h0000_0513);
    vecs[1]  = mk_rd(2'b01, 32'h0000_2000, 32'h0000_F234, 4);
    vecs[2]  = mk_wr(2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 5);
    vecs[3]  = mk_rd(2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 6);
    vecs[4]  = mk_rd(2'b00, 32'h0000_0041, 32'h0000_00BE, 3);
    vecs[5]  = mk_wr(2'b01, 32'h0000_0302, 32'h1234_5678, 3);
    vecs[6]  = mk_wr(2'b00, 32'h0000_0300, 32'hAAAA_AA99, 2);
    vecs[7]  = mk_rd(2'b11, 32'h0000_0300, 32'h5678_2299, 6);
    vecs[8]  = mk_if(32'h0000_0300, 32'h5678_2299);
    vecs[9]  = mk_rd(2'b01, 32'hFFFE_0301, 32'h0000_7822, 4);
    vecs[10] = mk_wr(2'b01, 32'h0001_FFFF, 32'h0000_BBCC, 3);
    vecs[11] = mk_rd(2'b00, 32'h0001_FFFF, 32'h0000_00CC, 3);
    vecs[12] = mk_if(32'hFFFF_FFFE, 32'h7EBB_CC5A);
    vecs[13] = mk_rd(2'b00, 32'h0001_FFFE, 32'h0000_005A, 3);

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_ram", {ram_addr_out, ram_wr_out, ram_dout}, 32'h0);
    check("rst_done", {30'h0, if_done_out, mem_done_out}, 32'h0);
    check("rst_if_data", if_data_out, 32'h0);
    check("rst_mem_data", mem_rdata_out, 32'h0);
    rst_in = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Simultaneous requests: MEM first, IF accepted after mem_req_in drops
    mem_req_in = 1'b1; mem_we_in = 1'b0; mem_len_in = 2'b01; mem_addr_in = 32'h2000;
    if_req_in = 1'b1; if_addr_in = 32'h100;
    mem_cyc = 0; if_cyc = 0; bad_flag = 0; mem_got = 32'h0; if_got = 32'h0;
    for (int c = 1; c <= 16 && if_cyc == 0; c++) begin
      @(negedge clk);
      if (mem_done_out) begin mem_cyc = c; mem_got = mem_rdata_out; mem_req_in = 1'b0; end
      if (if_done_out) begin if_cyc = c; if_got = if_data_out; if_req_in = 1'b0; end
      else if (if_stall_out !== 1'b1) bad_flag = 1;
    end
    if_req_in = 1'b0; mem_req_in = 1'b0;
    check("simul_mem_cycle", 32'(mem_cyc), 32'd4);
    check("simul_mem_data", mem_got, 32'h0000_F234);
    check("simul_if_cycle", 32'(if_cyc), 32'd11);
    check("simul_if_data", if_got, 32'h0000_0513);
    check("simul_if_stall", 32'(bad_flag), 32'h0);
    @(negedge clk);

    // IF flush at cnt=2, then MEM must be accepted immediately
    if_req_in = 1'b1; if_addr_in = 32'h300;
    @(negedge clk); @(negedge clk); @(negedge clk);
    if_req_in = 1'b0;
    @(negedge clk);
    check("flush_no_done", {31'h0, if_done_out}, 32'h0);
    check("flush_if_hold", if_data_out, 32'h0000_0513);
    run_op(mk_rd(2'b00, 32'h0000_0300, 32'h0000_0099, 3), "flush_mem");
    run_op(mk_if(32'h0000_0200, 32'h0010_0093), "flush_refetch");

    // Reset during a word store after two bytes
    wr_q.push_back('{addr: 17'h00500, data: 8'h11});
    wr_q.push_back('{addr: 17'h00501, data: 8'h22});
    mem_req_in = 1'b1; mem_we_in = 1'b1; mem_len_in = 2'b10;
    mem_addr_in = 32'h500; mem_wdata_in = 32'h4433_2211;
    @(negedge clk); @(negedge clk);
    rst_in = 1'b1; mem_req_in = 1'b0;
    @(negedge clk);
    check("rstwr_ram", {ram_addr_out, ram_wr_out, ram_dout}, 32'h0);
    check("rstwr_flags", {28'h0, if_done_out, mem_done_out, if_stall_out, mem_stall_out}, 32'h0);
    check("rstwr_data", if_data_out | mem_rdata_out, 32'h0);
    rst_in = 1'b0;
    bad_flag = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_done_out || if_done_out) bad_flag = 1;
    end
    check("rstwr_no_done", 32'(bad_flag), 32'h0);
    check("rstwr_wr_count", 32'(wr_q.size()), 32'h0);
    check("rstwr_untouched", {16'h0, ram[17'h00503], ram[17'h00502]}, 32'h0000_FFEE);
    run_op(mk_rd(2'b10, 32'h0000_0500, 32'hFFEE_2211, 6), "rstwr_readback");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
